// File: rtl/bram_arb_pkg.sv
// Shared types for the Conv2d BRAM port arbiter: FSM state encoding and requester indices.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic REQ_LOADER = 1'b0;
    localparam logic REQ_CONV   = 1'b1;

endpackage

// File: rtl/rr_lock_fsm.sv
// Round-robin grant generator with a bounded burst lock; owns last-winner, state and beat count.
module rr_lock_fsm
    import bram_arb_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_0,
    input  logic req_1,
    input  logic lock_0,
    input  logic lock_1,
    output logic gnt_0,
    output logic gnt_1
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_t     state, state_n;
    logic           last, last_n;
    logic [CW-1:0]  lock_cnt, lock_cnt_n;
    logic           g0, g1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= REQ_CONV;
            lock_cnt <= '0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            lock_cnt <= lock_cnt_n;
        end
    end

    // A lock of one beat is already exhausted, so MAX_LOCK=1 never leaves IDLE.
    always_comb begin
        g0         = 1'b0;
        g1         = 1'b0;
        state_n    = state;
        last_n     = last;
        lock_cnt_n = lock_cnt;
        case (state)
            IDLE: begin
                if (req_0 && (!req_1 || last == REQ_CONV)) begin
                    g0     = 1'b1;
                    last_n = REQ_LOADER;
                    if (lock_0 && MAX_LOCK > 1) begin
                        state_n    = LOCK0;
                        lock_cnt_n = CW'(1);
                    end
                end else if (req_1) begin
                    g1     = 1'b1;
                    last_n = REQ_CONV;
                    if (lock_1 && MAX_LOCK > 1) begin
                        state_n    = LOCK1;
                        lock_cnt_n = CW'(1);
                    end
                end
            end
            LOCK0: begin
                if (!req_0) begin
                    state_n = IDLE;
                end else begin
                    g0         = 1'b1;
                    lock_cnt_n = lock_cnt + CW'(1);
                    if (!lock_0 || lock_cnt_n == CW'(MAX_LOCK))
                        state_n = IDLE;
                end
            end
            LOCK1: begin
                if (!req_1) begin
                    state_n = IDLE;
                end else begin
                    g1         = 1'b1;
                    lock_cnt_n = lock_cnt + CW'(1);
                    if (!lock_1 || lock_cnt_n == CW'(MAX_LOCK))
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign gnt_0 = g0 & rst_n;
    assign gnt_1 = g1 & rst_n;

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester BRAM port arbiter (loader / conv reader) with read-return tagging.
// Optional stall counters enabled by defining BRAM_ARB_PERF_EN.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_LOCK   = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic                  lock_0,
    input  logic                  lock_1,
    input  logic                  we_0,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic                  rvalid_0,
    output logic                  rvalid_1,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
`ifdef BRAM_ARB_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [CNT_WIDTH-1:0]  stall_cnt_0,
    output logic [CNT_WIDTH-1:0]  stall_cnt_1
`endif
);

    rr_lock_fsm #(
        .MAX_LOCK (MAX_LOCK)
    ) u_fsm (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_0  (req_0),
        .req_1  (req_1),
        .lock_0 (lock_0),
        .lock_1 (lock_1),
        .gnt_0  (gnt_0),
        .gnt_1  (gnt_1)
    );

    // Requester 0 owns the address/data bus whenever requester 1 is not granted.
    assign bram_en   = gnt_0 | gnt_1;
    assign bram_we   = (gnt_0 & we_0) | (gnt_1 & we_1);
    assign bram_addr = gnt_1 ? addr_1  : addr_0;
    assign bram_din  = gnt_1 ? wdata_1 : wdata_0;
    assign rdata_0   = bram_dout;
    assign rdata_1   = bram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
        end else begin
            rvalid_0 <= gnt_0 & ~we_0;
            rvalid_1 <= gnt_1 & ~we_1;
        end
    end

`ifdef BRAM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_0 <= '0;
            stall_cnt_1 <= '0;
        end else if (perf_clr) begin
            stall_cnt_0 <= '0;
            stall_cnt_1 <= '0;
        end else begin
            if (req_0 && !gnt_0 && stall_cnt_0 != '1)
                stall_cnt_0 <= stall_cnt_0 + CNT_WIDTH'(1);
            if (req_1 && !gnt_1 && stall_cnt_1 != '1)
                stall_cnt_1 <= stall_cnt_1 + CNT_WIDTH'(1);
        end
    end
`else
    logic unused_perf;
    assign unused_perf = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter; a second instance with MAX_LOCK=4 covers forced release.
module tb_bram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_0, req_1, lock_0, lock_1, we_0, we_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;

    logic          gnt_0, gnt_1, rvalid_0, rvalid_1, bram_en, bram_we;
    logic [DW-1:0] rdata_0, rdata_1, bram_din, bram_dout;
    logic [AW-1:0] bram_addr;

    logic          g4_0, g4_1, rv4_0, rv4_1, en4, we4;
    logic [DW-1:0] rd4_0, rd4_1, din4;
    logic [AW-1:0] addr4;

`ifdef BRAM_ARB_PERF_EN
    logic          perf_clr;
    logic [31:0]   stall_cnt_0, stall_cnt_1, sc4_0, sc4_1;
`endif

    logic [DW-1:0] mem [0:1023];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Read-first single-port BRAM behind the default instance
    always @(posedge clk) begin
        if (bram_en) begin
            bram_dout <= mem[bram_addr];
            if (bram_we)
                mem[bram_addr] <= bram_din;
        end
    end

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .req_1(req_1), .lock_0(lock_0), .lock_1(lock_1),
        .we_0(we_0), .we_1(we_1), .addr_0(addr_0), .addr_1(addr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
`ifdef BRAM_ARB_PERF_EN
        , .perf_clr(perf_clr), .stall_cnt_0(stall_cnt_0), .stall_cnt_1(stall_cnt_1)
`endif
    );

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .req_1(req_1), .lock_0(lock_0), .lock_1(lock_1),
        .we_0(we_0), .we_1(we_1), .addr_0(addr_0), .addr_1(addr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(g4_0), .gnt_1(g4_1), .rvalid_0(rv4_0), .rvalid_1(rv4_1),
        .rdata_0(rd4_0), .rdata_1(rd4_1),
        .bram_en(en4), .bram_we(we4), .bram_addr(addr4),
        .bram_din(din4), .bram_dout(bram_dout)
`ifdef BRAM_ARB_PERF_EN
        , .perf_clr(perf_clr), .stall_cnt_0(sc4_0), .stall_cnt_1(sc4_1)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0;
        we_0 = 0; we_1 = 0; addr_0 = '0; addr_1 = '0;
        wdata_0 = '0; wdata_1 = '0;
`ifdef BRAM_ARB_PERF_EN
        perf_clr = 0;
`endif
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 0;
        req_0 = 1; req_1 = 1;
        #3;
        checks++; if (gnt_0 !== 1'b0) begin fails++; $display("[TB] FAIL rst_gnt0 got %b expected 0", gnt_0); end
        checks++; if (gnt_1 !== 1'b0) begin fails++; $display("[TB] FAIL rst_gnt1 got %b expected 0", gnt_1); end
        checks++; if (bram_en !== 1'b0) begin fails++; $display("[TB] FAIL rst_en got %b expected 0", bram_en); end
        step();
        @(negedge clk);
        checks++; if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0) begin fails++; $display("[TB] FAIL rst_rvalid got %b%b expected 00", rvalid_0, rvalid_1); end
        do_reset();
    endtask

    task automatic test_single_read;
        do_reset();
        req_1 = 1; we_1 = 0; addr_1 = 10'h005;
        @(negedge clk);
        checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) begin fails++; $display("[TB] FAIL rd_gnt got %b%b expected 01", gnt_0, gnt_1); end
        checks++; if (bram_en !== 1'b1 || bram_we !== 1'b0) begin fails++; $display("[TB] FAIL rd_en_we got %b%b expected 10", bram_en, bram_we); end
        checks++; if (bram_addr !== 10'h005) begin fails++; $display("[TB] FAIL rd_addr got %h expected 005", bram_addr); end
        step();
        req_1 = 0;
        @(negedge clk);
        checks++; if (rvalid_1 !== 1'b1) begin fails++; $display("[TB] FAIL rd_rvalid1 got %b expected 1", rvalid_1); end
        checks++; if (rdata_1 !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL rd_rdata1 got %h expected deadbeef", rdata_1); end
        checks++; if (rvalid_0 !== 1'b0) begin fails++; $display("[TB] FAIL rd_rvalid0 got %b expected 0", rvalid_0); end
        step();
        @(negedge clk);
        checks++; if (rvalid_1 !== 1'b0) begin fails++; $display("[TB] FAIL rd_rvalid1_drop got %b expected 0", rvalid_1); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp0;
        exp0 = 4'b0101;
        do_reset();
        req_0 = 1; req_1 = 1; we_0 = 1; we_1 = 1;
        addr_0 = 10'h010; addr_1 = 10'h020;
        wdata_0 = 32'hA0A0A0A0; wdata_1 = 32'hB1B1B1B1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (gnt_0 !== exp0[i] || gnt_1 !== ~exp0[i]) begin fails++; $display("[TB] FAIL rr_gnt[%0d] got %b%b expected %b%b", i, gnt_0, gnt_1, exp0[i], ~exp0[i]); end
            checks++; if (bram_addr !== (exp0[i] ? 10'h010 : 10'h020)) begin fails++; $display("[TB] FAIL rr_addr[%0d] got %h", i, bram_addr); end
            checks++; if (bram_din !== (exp0[i] ? 32'hA0A0A0A0 : 32'hB1B1B1B1)) begin fails++; $display("[TB] FAIL rr_din[%0d] got %h", i, bram_din); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_lock_burst;
        do_reset();
        req_1 = 1; we_1 = 0; addr_1 = 10'h005;
        req_0 = 1; we_0 = 1;
        for (int i = 0; i < 8; i++) begin
            lock_0 = (i < 7);
            addr_0 = AW'(i);
            wdata_0 = 32'h100 + i;
            @(negedge clk);
            checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin fails++; $display("[TB] FAIL lock_gnt[%0d] got %b%b expected 10", i, gnt_0, gnt_1); end
            checks++; if (bram_we !== 1'b1 || bram_addr !== AW'(i)) begin fails++; $display("[TB] FAIL lock_wr[%0d] got we=%b addr=%h", i, bram_we, bram_addr); end
            step();
        end
        req_0 = 0; lock_0 = 0;
        @(negedge clk);
        checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) begin fails++; $display("[TB] FAIL lock_handover got %b%b expected 01", gnt_0, gnt_1); end
        step();
        req_1 = 0;
        @(negedge clk);
        checks++; if (rvalid_1 !== 1'b1 || rdata_1 !== 32'h105) begin fails++; $display("[TB] FAIL lock_readback got %b/%h expected 1/00000105", rvalid_1, rdata_1); end
        step();
    endtask

    task automatic test_forced_release;
        logic [5:0] exp0;
        exp0 = 6'b101111;
        do_reset();
        req_0 = 1; lock_0 = 1; we_0 = 1;
        req_1 = 1; we_1 = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (g4_0 !== exp0[i] || g4_1 !== ~exp0[i]) begin fails++; $display("[TB] FAIL force_gnt[%0d] got %b%b expected %b%b", i, g4_0, g4_1, exp0[i], ~exp0[i]); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        req_0 = 1; lock_0 = 1; we_0 = 0; addr_0 = 10'h005;
        req_1 = 1; we_1 = 0;
        step();
        @(negedge clk);
        checks++; if (rvalid_0 !== 1'b1 || gnt_0 !== 1'b1) begin fails++; $display("[TB] FAIL mid_pre got rv=%b g=%b expected 1/1", rvalid_0, gnt_0); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) begin fails++; $display("[TB] FAIL mid_gnt got %b%b expected 00", gnt_0, gnt_1); end
        checks++; if (bram_en !== 1'b0) begin fails++; $display("[TB] FAIL mid_en got %b expected 0", bram_en); end
        checks++; if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0) begin fails++; $display("[TB] FAIL mid_rvalid got %b%b expected 00", rvalid_0, rvalid_1); end
        step();
        rst_n = 1; lock_0 = 0;
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin fails++; $display("[TB] FAIL mid_tie got %b%b expected 10", gnt_0, gnt_1); end
        step();
        idle_inputs();
    endtask

`ifdef BRAM_ARB_PERF_EN
    task automatic test_perf;
        do_reset();
        req_1 = 1; we_1 = 1;
        req_0 = 1; we_0 = 1;
        for (int i = 0; i < 8; i++) begin
            lock_0 = (i < 7);
            step();
        end
        req_0 = 0; lock_0 = 0;
        @(negedge clk);
        checks++; if (stall_cnt_1 !== 32'd8) begin fails++; $display("[TB] FAIL perf_cnt1 got %0d expected 8", stall_cnt_1); end
        checks++; if (stall_cnt_0 !== 32'd0) begin fails++; $display("[TB] FAIL perf_cnt0 got %0d expected 0", stall_cnt_0); end
        step();
        req_1 = 0; perf_clr = 1;
        step();
        perf_clr = 0;
        @(negedge clk);
        checks++; if (stall_cnt_1 !== 32'd0) begin fails++; $display("[TB] FAIL perf_clr got %0d expected 0", stall_cnt_1); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[5] = 32'hDEADBEEF;
        bram_dout = '0;
        $display("[TB] starting bram_port_arbiter bench");
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_forced_release();
        test_reset_mid_burst();
`ifdef BRAM_ARB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one BRAM port (clock-enable/write-enable/address/data, 1-cycle read latency, read-first) between two requesters in the Conv2d datapath.
- Requester 0 is the feature-map loader (mostly writes); requester 1 is the conv window reader (mostly reads).
- Round-robin arbitration, with optional burst lock bounded by MAX_LOCK, plus per-requester read-return tagging.

Parameters:
- DATA_WIDTH, 32, BRAM word width.
- ADDR_WIDTH, 10, BRAM address width.
- MAX_LOCK, 16, maximum consecutive granted beats to one requester under lock; must be ≥1.
- CNT_WIDTH, 32, width of perf counters (only used with the optional feature).

Ports:
- clk  in  1  single system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_0 / req_1  in  1  access request, held until granted.
- lock_0 / lock_1  in  1  request burst hold after this beat.
- we_0 / we_1  in  1  1 = write, 0 = read.
- addr_0 / addr_1  in  ADDR_WIDTH  access address.
- wdata_0 / wdata_1  in  DATA_WIDTH  write data.
- gnt_0 / gnt_1  out  1  combinational; beat accepted this cycle.
- rvalid_0 / rvalid_1  out  1  registered; read data valid.
- rdata_0 / rdata_1  out  DATA_WIDTH  read data, meaningful only while rvalid.
- bram_en  out  1  to BRAM en.
- bram_we  out  1  to BRAM we.
- bram_addr  out  ADDR_WIDTH  to BRAM addr.
- bram_din  out  DATA_WIDTH  to BRAM din.
- bram_dout  in  DATA_WIDTH  from BRAM dout.

Behaviour:
- Reset: state=IDLE, last=1 (requester 0 wins first tie), lock_cnt=0, rvalid_0/1=0.
- While rst_n=0, gnt_0/1, bram_en and bram_we are forced 0.
- Grant is combinational. At most one of gnt_0/gnt_1 is high per cycle.
- The granted requester's we/addr/wdata drive the BRAM port that cycle. bram_en=gnt_0|gnt_1. bram_we=granted we. With no grant, addr/din are don't-care but held at requester 0's values.
- Handshake: a beat transfers on req_x & gnt_x. The requester may change addr/we/wdata the next cycle. req may drop only after a grant.
- Read latency 1: rvalid_x <= gnt_x & ~we_x. rdata_0 = rdata_1 = bram_dout (combinational route). Write beats produce no rvalid. Back-to-back reads give rvalid every cycle.
- IDLE:
  - Only one request: grant it.
  - Both request: grant the requester ≠ last.
  - On grant to x, last <= x.
  - If lock_x is also high: go to LOCKx with lock_cnt <= 1.
- LOCKx:
  - Only x may be granted; the other requester stalls.
  - Each granted beat increments lock_cnt.
  - Return to IDLE when any of the following holds:
    - req_x=0 (abandon; no grant that cycle);
    - granted beat with lock_x=0 (final beat);
    - lock_cnt reaches MAX_LOCK on a granted beat (forced release).
- After a forced release, if the other requester is requesting, the next IDLE arbitration grants it regardless of lock.
- MAX_LOCK=1 degenerates to pure round-robin.
- Simultaneous requests on the first cycle after reset: gnt_0.
- Reset mid-burst: everything returns to IDLE immediately. Any in-flight rvalid is cleared; the requester must reissue.
- Address and data are not checked; same-address read/write ordering is grant order.

Optional Feature:
- BRAM_ARB_PERF_EN defined: adds outputs stall_cnt_0 and stall_cnt_1 (CNT_WIDTH), reset 0.
  - Each increments on cycles with req_x & ~gnt_x and saturates at all-ones.
  - Synchronous clear input perf_clr (1 bit); clear has priority over increment.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package bram_arb_pkg holds:
  - state encoding IDLE/LOCK0/LOCK1 (2-bit typedef);
  - requester-index constants REQ_LOADER=0 and REQ_CONV=1.
- Sub-module rr_lock_fsm holds last, state and lock_cnt, outputting gnt_0/gnt_1.
- The top module does muxing, rvalid registers and perf counters.

Test Plan:
- Single read: after reset, req_1=1, we_1=0, addr_1=0x005, BRAM[5]=0xDEADBEEF, for one cycle. Expect gnt_1 the same cycle, then rvalid_1=1 with rdata_1=0xDEADBEEF the next cycle; rvalid_0 stays 0.
- Tie/round-robin: req_0 and req_1 held 4 cycles with lock=0. Expect grant sequence 0,1,0,1; the first tie after reset goes to 0.
- Lock burst: req_0=1, lock_0=1, writes to addr 0..7, req_1 held. Expect gnt_0 for 8 beats with gnt_1=0. On beat 8 with lock_0=0, gnt_1 is asserted the next cycle.
- Forced release: MAX_LOCK=4, lock_0 held continuously, req_1 held. Expect 4 gnt_0 beats, then gnt_1 for one beat, then requester 0 regains.
- Async reset mid-burst: assert rst_n=0 during LOCK0 with a pending read. Expect gnt_0/1, bram_en and rvalid_0/1 to be 0 immediately (no clock edge). After release, a tie grants 0.
- With BRAM_ARB_PERF_EN: hold req_1 stalled for 8 lock beats → stall_cnt_1=8. Pulse perf_clr → 0 the next cycle.
